// File: rtl/lut_pkg.sv
// Shared helpers for the banked lookup table: bank depth, lane slicing, swap FSM states.
// Latency: none (types and constant functions only).
// Backpressure: n/a.
package lut_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } swap_state_e;

  // Words per bank for a given address width.
  function automatic int unsigned lut_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  // LSB position of lane k in a bus of lanes each w bits wide.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned w);
    return lane * w;
  endfunction

endpackage

// File: rtl/lut_bank_ram.sv
// One table bank: single write port, LANES combinational read ports.
// Latency: write lands on the next clock edge; reads are combinational.
// Backpressure: none; the caller gates the write enable.
import lut_pkg::*;

module lut_bank_ram #(
  parameter int TW    = 32,
  parameter int AW    = 8,
  parameter int LANES = 1
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [TW-1:0]       wdata,
  input  logic [LANES*AW-1:0] raddr,
  output logic [LANES*TW-1:0] rdata
);

  localparam int DEPTH = lut_depth(AW);

  // Table storage is deliberately not reset.
  logic [TW-1:0] mem_q [DEPTH];

  // Write port: one word per enabled cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read ports: each lane indexes the array independently.
  always_comb begin
    rdata = '0;
    for (int k = 0; k < LANES; k++) begin
      rdata[lane_lsb(k, TW) +: TW] = mem_q[raddr[lane_lsb(k, AW) +: AW]];
    end
  end

endmodule

// File: rtl/lookup_table_banked.sv
// Double-banked multi-lane lookup table; shadow bank loads, swaps at packet boundary. Optional LUT_LOAD_STATUS_EN.
// Latency: 1 cycle from input handshake to registered output beat.
// Backpressure: data_in_tready = !out_valid | data_out_tready; load stalls while a swap is pending.
import lut_pkg::*;

module lookup_table_banked #(
  parameter int TDATA_WIDTH   = 32,
  parameter int ADDRESS_WIDTH = 8,
  parameter int LANES         = 1
) (
  input  logic                             aclk,
  input  logic                             areset,
  output logic                             data_in_tready,
  input  logic [LANES*ADDRESS_WIDTH-1:0]   data_in_tdata,
  input  logic                             data_in_tlast,
  input  logic                             data_in_tvalid,
  input  logic                             data_out_tready,
  output logic [LANES*TDATA_WIDTH-1:0]     data_out_tdata,
  output logic                             data_out_tlast,
  output logic                             data_out_tvalid,
  output logic                             data_load_tready,
  input  logic [TDATA_WIDTH-1:0]           data_load_tdata,
  input  logic                             data_load_tlast,
  input  logic                             data_load_tvalid,
  output logic                             active_bank
`ifdef LUT_LOAD_STATUS_EN
  ,
  output logic                             load_overflow,
  output logic [15:0]                      swap_count
`endif
);

  localparam int OW = LANES * TDATA_WIDTH;

  logic [OW-1:0]            out_dat_q, out_dat_d;
  logic                     out_vld_q, out_vld_d;
  logic                     out_last_q, out_last_d;
  logic                     active_bank_q, active_bank_d;
  logic [ADDRESS_WIDTH-1:0] load_addr_q, load_addr_d;
  logic                     in_packet_q, in_packet_d;
  swap_state_e              swap_state_q, swap_state_d;

  logic          in_hs, out_hs, ld_hs, swap_fire;
  logic          we0, we1;
  logic [OW-1:0] rd0, rd1, rd_sel;

  // Bank 0 and bank 1; only the shadow bank (the one not selected for lookups) is ever written.
  lut_bank_ram #(.TW(TDATA_WIDTH), .AW(ADDRESS_WIDTH), .LANES(LANES)) u_bank0 (
    .clk(aclk), .we(we0), .waddr(load_addr_q), .wdata(data_load_tdata),
    .raddr(data_in_tdata), .rdata(rd0)
  );

  lut_bank_ram #(.TW(TDATA_WIDTH), .AW(ADDRESS_WIDTH), .LANES(LANES)) u_bank1 (
    .clk(aclk), .we(we1), .waddr(load_addr_q), .wdata(data_load_tdata),
    .raddr(data_in_tdata), .rdata(rd1)
  );

  // Handshakes, bank select, output stage, load address and swap FSM next-state.
  always_comb begin
    data_in_tready   = !out_vld_q || data_out_tready;
    data_load_tready = (swap_state_q == IDLE);
    in_hs            = data_in_tvalid && data_in_tready;
    out_hs           = out_vld_q && data_out_tready;
    ld_hs            = data_load_tvalid && data_load_tready;
    we0              = ld_hs && active_bank_q;
    we1              = ld_hs && !active_bank_q;
    rd_sel           = active_bank_q ? rd1 : rd0;

    out_dat_d     = out_dat_q;
    out_vld_d     = out_vld_q;
    out_last_d    = out_last_q;
    active_bank_d = active_bank_q;
    load_addr_d   = load_addr_q;
    in_packet_d   = in_packet_q;
    swap_state_d  = swap_state_q;
    swap_fire     = 1'b0;

    if (in_hs) begin
      out_dat_d   = rd_sel;
      out_vld_d   = 1'b1;
      out_last_d  = data_in_tlast;
      in_packet_d = !data_in_tlast;
    end else if (out_hs) begin
      out_vld_d = 1'b0;
    end

    if (ld_hs) begin
      load_addr_d = data_load_tlast ? '0 : load_addr_q + 1'b1;
    end

    case (swap_state_q)
      IDLE: begin
        if (ld_hs && data_load_tlast) begin
          swap_state_d = PENDING;
        end
      end
      PENDING: begin
        // The tlast beat itself still reads the old bank this cycle.
        if ((!in_packet_q && !in_hs) || (in_hs && data_in_tlast)) begin
          swap_fire     = 1'b1;
          swap_state_d  = IDLE;
          active_bank_d = !active_bank_q;
        end
      end
      default: swap_state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      out_dat_q     <= '0;
      out_vld_q     <= 1'b0;
      out_last_q    <= 1'b0;
      active_bank_q <= 1'b0;
      load_addr_q   <= '0;
      in_packet_q   <= 1'b0;
      swap_state_q  <= IDLE;
    end else begin
      out_dat_q     <= out_dat_d;
      out_vld_q     <= out_vld_d;
      out_last_q    <= out_last_d;
      active_bank_q <= active_bank_d;
      load_addr_q   <= load_addr_d;
      in_packet_q   <= in_packet_d;
      swap_state_q  <= swap_state_d;
    end
  end

  assign data_out_tdata  = out_dat_q;
  assign data_out_tvalid = out_vld_q;
  assign data_out_tlast  = out_last_q;
  assign active_bank     = active_bank_q;

`ifdef LUT_LOAD_STATUS_EN
  logic        overflow_q, overflow_d;
  logic [15:0] swap_cnt_q, swap_cnt_d;

  // Sticky wrap-without-tlast flag and free-running swap counter.
  always_comb begin
    overflow_d = overflow_q;
    swap_cnt_d = swap_cnt_q;
    if (ld_hs && !data_load_tlast && (load_addr_q == {ADDRESS_WIDTH{1'b1}})) begin
      overflow_d = 1'b1;
    end
    if (swap_fire) begin
      swap_cnt_d = swap_cnt_q + 16'd1;
    end
  end

  // Status registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      overflow_q <= 1'b0;
      swap_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      swap_cnt_q <= swap_cnt_d;
    end
  end

  assign load_overflow = overflow_q;
  assign swap_count    = swap_cnt_q;
`endif

endmodule

// File: tb/tb_lookup_table_banked.sv
// Self-checking bench for lookup_table_banked with 4 lanes: directed vectors, corner sequences, random traffic vs model.
// Latency: expects output beat 1 cycle after each input handshake.
// Backpressure: random and directed data_out_tready stalls.
module tb_lookup_table_banked;

  localparam int TW = 32;
  localparam int AW = 8;
  localparam int LN = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_rdy;
  logic [LN*AW-1:0]  in_dat = '0;
  logic              in_last = 1'b0;
  logic              in_vld = 1'b0;
  logic              out_rdy = 1'b1;
  logic [LN*TW-1:0]  out_dat;
  logic              out_last;
  logic              out_vld;
  logic              ld_rdy;
  logic [TW-1:0]     ld_dat = '0;
  logic              ld_last = 1'b0;
  logic              ld_vld = 1'b0;
  logic              act_bank;
`ifdef LUT_LOAD_STATUS_EN
  logic              load_overflow;
  logic [15:0]       swap_count;
`endif

  lookup_table_banked #(.TDATA_WIDTH(TW), .ADDRESS_WIDTH(AW), .LANES(LN)) dut (
    .aclk(clk), .areset(rst),
    .data_in_tready(in_rdy), .data_in_tdata(in_dat), .data_in_tlast(in_last), .data_in_tvalid(in_vld),
    .data_out_tready(out_rdy), .data_out_tdata(out_dat), .data_out_tlast(out_last), .data_out_tvalid(out_vld),
    .data_load_tready(ld_rdy), .data_load_tdata(ld_dat), .data_load_tlast(ld_last), .data_load_tvalid(ld_vld),
    .active_bank(act_bank)
`ifdef LUT_LOAD_STATUS_EN
    , .load_overflow(load_overflow), .swap_count(swap_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (evaluated at negedge) ----------------
  typedef struct { logic [127:0] dat; logic last; } beat_t;
  beat_t         exp_q[$];
  logic [31:0]   bank_m [2][256];
  bit            model_ok = 0;
  bit            act_m, pend_m, inpkt_m, vld_m, ovf_m;
  int            laddr_m;
  int            swaps_m;

  always @(negedge clk) begin
    bit in_hs, out_hs, ld_hs;
    beat_t b;
    if (model_ok) begin
      check("in_tready", in_rdy, !vld_m || out_rdy);
      check("out_tvalid", out_vld, vld_m);
      check("active_bank", act_bank, act_m);
      check("load_tready", ld_rdy, !pend_m);
      if (vld_m && exp_q.size() > 0) begin
        check("sb_data", out_dat, exp_q[0].dat);
        check("sb_last", out_last, exp_q[0].last);
      end
`ifdef LUT_LOAD_STATUS_EN
      check("load_overflow", load_overflow, ovf_m);
      check("swap_count", swap_count, swaps_m[15:0]);
`endif
    end
    if (rst) begin
      model_ok = 1; act_m = 0; pend_m = 0; inpkt_m = 0; vld_m = 0; ovf_m = 0;
      laddr_m = 0; swaps_m = 0;
      exp_q.delete();
    end else if (model_ok) begin
      in_hs  = in_vld && (!vld_m || out_rdy);
      out_hs = vld_m && out_rdy;
      ld_hs  = ld_vld && !pend_m;
      if (out_hs && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_hs) begin
        for (int k = 0; k < LN; k++) b.dat[k*32 +: 32] = bank_m[act_m][in_dat[k*8 +: 8]];
        b.last = in_last;
        exp_q.push_back(b);
        vld_m = 1;
      end else if (out_hs) vld_m = 0;
      if (ld_hs) begin
        bank_m[!act_m][laddr_m] = ld_dat;
        if (ld_last) begin laddr_m = 0; pend_m = 1; end
        else begin
          if (laddr_m == 255) ovf_m = 1;
          laddr_m = (laddr_m + 1) % 256;
        end
      end else if (pend_m && ((!inpkt_m && !in_hs) || (in_hs && in_last))) begin
        act_m = !act_m; pend_m = 0; swaps_m++;
      end
      if (in_hs) inpkt_m = !in_last;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load_words(input logic [31:0] base, input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      ld_vld = 1; ld_dat = base + i; ld_last = with_last && (i == n - 1);
      while (!ld_rdy && w < 50) begin tick(); w++; end
      if (!ld_rdy) begin
        n_chk++;
        $display("FAIL load_wait: data_load_tready stuck at %b, required 1", ld_rdy);
      end
      tick();
    end
    ld_vld = 0; ld_last = 0;
  endtask

  task automatic beat(input logic [31:0] a, input bit last);
    in_vld = 1; in_dat = a; in_last = last;
    tick();
    in_vld = 0; in_last = 0;
  endtask

  typedef struct { logic [31:0] addrs; logic last; logic [127:0] exp; } vec_t;
  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{32'h05050505, 1'b1, {4{32'h00001005}}};
    vecs[1] = '{32'hFFFFFFFF, 1'b1, {4{32'h000010FF}}};
    vecs[2] = '{32'h03020100, 1'b1, {32'h1003, 32'h1002, 32'h1001, 32'h1000}};
    vecs[3] = '{32'h807F01FE, 1'b0, {32'h1080, 32'h107F, 32'h1001, 32'h10FE}};
    vecs[4] = '{32'h40302010, 1'b1, {32'h1040, 32'h1030, 32'h1020, 32'h1010}};

    // Reset values
    repeat (2) tick();
    rst = 0;
    check("rst_out_tvalid", out_vld, 1'b0);
    check("rst_out_tlast", out_last, 1'b0);
    check("rst_out_tdata", out_dat, '0);
    check("rst_active_bank", act_bank, 1'b0);
    check("rst_load_tready", ld_rdy, 1'b1);

    // First table image into bank 1, then idle swap
    load_words(32'h1000, 256, 1'b1);
    check("idle_swap_pend_bank", act_bank, 1'b0);
    check("idle_swap_pend_ready", ld_rdy, 1'b0);
    tick();
    check("idle_swap_bank", act_bank, 1'b1);
    check("idle_swap_ready", ld_rdy, 1'b1);

    // Table-driven single-beat lookups, 1-cycle latency
    for (int i = 0; i < 5; i++) begin
      beat(vecs[i].addrs, vecs[i].last);
      check($sformatf("vec%0d_valid", i), out_vld, 1'b1);
      check($sformatf("vec%0d_data", i), out_dat, vecs[i].exp);
      check($sformatf("vec%0d_last", i), out_last, vecs[i].last);
    end
    tick();

    // Backpressure: stall a beat at the output for 3 cycles
    beat(32'h10101010, 1'b1);
    out_rdy = 0;
    in_vld = 1; in_dat = 32'h11111111; in_last = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", out_vld, 1'b1);
      check("bp_data", out_dat, {4{32'h00001010}});
      check("bp_last", out_last, 1'b1);
      check("bp_in_tready", in_rdy, 1'b0);
      tick();
    end
    out_rdy = 1;
    tick();
    in_vld = 0;
    check("bp_next_data", out_dat, {4{32'h00001011}});
    tick();
    check("bp_drained", out_vld, 1'b0);

    // Boundary swap: new image finishes mid-packet
    beat(32'h04030201, 1'b0);
    load_words(32'h2000, 256, 1'b1);
    repeat (3) tick();
    check("bnd_load_blocked", ld_rdy, 1'b0);
    check("bnd_bank_held", act_bank, 1'b1);
    beat(32'h04030201, 1'b0);
    check("bnd_beat2", out_dat, {32'h1004, 32'h1003, 32'h1002, 32'h1001});
    beat(32'h04030201, 1'b0);
    check("bnd_beat3_ready", ld_rdy, 1'b0);
    beat(32'h04030201, 1'b1);
    check("bnd_beat4", out_dat, {32'h1004, 32'h1003, 32'h1002, 32'h1001});
    check("bnd_swapped", act_bank, 1'b0);
    check("bnd_ready_back", ld_rdy, 1'b1);
    beat(32'h04030201, 1'b1);
    check("bnd_new_pkt", out_dat, {32'h2004, 32'h2003, 32'h2002, 32'h2001});
    tick();

    // Reset mid-load: address restarts at 0
    load_words(32'h3000 + 32'h00F6, 10, 1'b0);
    rst = 1;
    tick();
    rst = 0;
    check("rml_bank", act_bank, 1'b0);
    check("rml_ready", ld_rdy, 1'b1);
    check("rml_out_valid", out_vld, 1'b0);
    load_words(32'h3000, 256, 1'b1);
    tick();
    check("rml_swap", act_bank, 1'b1);
    beat(32'hFF090A00, 1'b1);
    check("rml_data", out_dat, {32'h30FF, 32'h3009, 32'h300A, 32'h3000});
    tick();

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      in_vld  = ($urandom_range(0, 1) == 1);
      in_dat  = $urandom;
      in_last = ($urandom_range(0, 3) == 0);
      out_rdy = ($urandom_range(0, 3) != 0);
      ld_vld  = ($urandom_range(0, 1) == 1);
      ld_dat  = $urandom;
      ld_last = ($urandom_range(0, 99) == 0);
      tick();
    end
    in_vld = 0; in_last = 0; ld_vld = 0; ld_last = 0; out_rdy = 1;
    repeat (3) tick();
    check("rand_drained", exp_q.size(), 0);

`ifdef LUT_LOAD_STATUS_EN
    rst = 1;
    tick();
    rst = 0;
    load_words(32'h4000, 255, 1'b0);
    check("ovf_not_yet", load_overflow, 1'b0);
    load_words(32'h5000, 2, 1'b0);
    check("ovf_set", load_overflow, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lookup_table_banked.md
Name: lookup_table_banked

Overview:
Parametrised, multi-lane, double-banked AXI-Stream lookup table for modem mapping and coefficient tables.
- Each input beat carries LANES addresses; the block returns LANES table words one cycle later, with full AXI backpressure.
- A separate load stream fills the inactive (shadow) bank while lookups continue.
- Banks swap only at a lookup packet boundary, so no frame ever mixes old and new table contents.

Parameters:
TDATA_WIDTH, 32, width of one table word
ADDRESS_WIDTH, 8, table address width; depth = 2**ADDRESS_WIDTH per bank
LANES, 1, addresses looked up per input beat (1..8)

Ports:
aclk  in  1  single clock for all buses
areset  in  1  synchronous reset, active-high
data_in_tready  out  1  lookup input ready
data_in_tdata  in  LANES*ADDRESS_WIDTH  lane k address at bits [k*AW +: AW]
data_in_tlast  in  1  end of lookup packet
data_in_tvalid  in  1  lookup input valid
data_out_tready  in  1  downstream ready
data_out_tdata  out  LANES*TDATA_WIDTH  lane k word at bits [k*TW +: TW]
data_out_tlast  out  1  registered copy of data_in_tlast
data_out_tvalid  out  1  output valid
data_load_tready  out  1  load ready
data_load_tdata  in  TDATA_WIDTH  table word to write
data_load_tlast  in  1  last word of table image
data_load_tvalid  in  1  load valid
active_bank  out  1  bank currently used by lookups

Behaviour:
- Interface: one clock, aclk; reset areset is synchronous and active-high. All state is reset synchronously.
- Reset values:
  - data_out_tvalid=0, data_out_tlast=0, data_out_tdata=0
  - active_bank=0, load address=0, swap_pending=0, in_packet=0
  - data_load_tready=1
  - Table contents are not reset. Reads before the first load return X in simulation; no guaranteed value in hardware.
- Lookup path: a single output register stage.
  - data_in_tready = !data_out_tvalid | data_out_tready (combinational).
  - On an input handshake, next cycle data_out_tdata = bank[active_bank][addr_k] for every lane, data_out_tvalid=1, and data_out_tlast = data_in_tlast.
  - If the output is stalled, tdata, tlast and tvalid hold stable.
  - If the output handshakes with no new input, data_out_tvalid falls to 0.
  - Latency is 1 cycle. Throughput is 1 beat/cycle while data_out_tready=1.
- in_packet flag:
  - Set on an input handshake with tlast=0.
  - Cleared on an input handshake with tlast=1.
- Load path:
  - Writes go to bank[!active_bank] at load_address on each load handshake.
  - load_address increments and wraps modulo depth. Words beyond depth overwrite from address 0.
  - The handshake with data_load_tlast=1 writes its word, resets load_address to 0, and sets swap_pending.
  - data_load_tready = !swap_pending. No further load is accepted until the swap completes.
- Swap FSM states: IDLE, PENDING.
  - IDLE -> PENDING on a load tlast handshake.
  - PENDING -> IDLE when either condition holds:
    - in_packet=0 and no input handshake this cycle, or
    - an input handshake with tlast=1 occurs this cycle.
  - The transition toggles active_bank.
  - The beat that carries tlast uses the old bank. The following beat uses the new bank.
- Simultaneous load write and lookup: there is no conflict, because they always target different banks.
- Reset asserted mid-load or mid-swap:
  - Load address returns to 0, pending is cleared, active_bank returns to 0.
  - Any partially written shadow contents stay in memory but are not selected.

Optional Feature:
LUT_LOAD_STATUS_EN.
- Defined: adds output ports load_overflow (1 bit) and swap_count (16 bits).
  - load_overflow is sticky. It sets when load_address wraps from depth-1 to 0 without tlast, and clears on reset.
  - swap_count increments on every bank swap, wraps at 2**16, and resets to 0.
- Undefined: neither port exists and no counter logic is generated. Lookup and load behaviour is identical in both builds.

Decomposition:
- Package lut_pkg holds:
  - localparam helpers: DEPTH = 2**ADDRESS_WIDTH, lane slice macros/functions;
  - the swap FSM state enum (IDLE, PENDING).
- One sub-module, lut_bank_ram: one write port and LANES combinational read ports over a TDATA_WIDTH x DEPTH array. It is instantiated twice.
- Bank select and the output register live in the top level.

Test Plan:
- Basic lookup:
  - Stimulus: load 256 words with value = 0x1000+addr, tlast on word 255; wait for the swap; then look up addr 0x05, then 0xFF.
  - Required: outputs 0x00001005 and 0x000010FF, each 1 cycle after its handshake; active_bank=1.
- Backpressure:
  - Stimulus: hold data_out_tready=0 for 3 cycles with a valid beat addr 0x10 at the output.
  - Required: tdata, tvalid and tlast are stable; data_in_tready=0. Releasing the stall drains with no beat lost or duplicated.
- Boundary swap:
  - Stimulus: start a 4-beat lookup packet; complete a second table load (value = 0x2000+addr) after beat 1.
  - Required: beats 1-4 return 0x1000-based data; the next packet returns 0x2000-based data; data_load_tready=0 until the tlast beat is accepted.
- Idle swap:
  - Stimulus: load tlast arrives with no lookup activity.
  - Required: active_bank toggles on the following cycle; data_load_tready returns to 1.
- Multi-lane (LANES=4):
  - Stimulus: data_in_tdata={0x03,0x02,0x01,0x00}.
  - Required: data_out_tdata={T[3],T[2],T[1],T[0]} in a single beat.
- Reset mid-load, and overflow:
  - Stimulus: assert areset after 10 load words.
  - Required: active_bank=0, data_load_tready=1, load address restarts at 0.
  - With LUT_LOAD_STATUS_EN, loading 257 words without tlast sets load_overflow=1.
